// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared encodings for the multi-cycle core control path
//             (ALU codes, opcode/funct values, controller state and ALU class).
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPE   = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI    = 4'd10,
        S_ORI     = 4'd11,
        S_IWB     = 4'd12,
        S_JUMP    = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    // Which ALU operation a state needs; FUNCT defers the choice to IR[5:0]
    typedef enum logic [2:0] {
        ALU_CLS_NONE  = 3'd0,
        ALU_CLS_ADD   = 3'd1,
        ALU_CLS_SUB   = 3'd2,
        ALU_CLS_OR    = 3'd3,
        ALU_CLS_FUNCT = 3'd4
    } alu_cls_t;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Purpose  : Maps the controller's ALU class and funct field to an ALU code;
//             o_valid drops only for an unsupported R-type funct.
//  Revision : 1.0  initial release
// ============================================================================
module alu_decoder
    import cpu_pkg::*;
(
    input  alu_cls_t    i_alu_cls,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alu_control,
    output logic        o_valid
);

    always_comb begin
        o_alu_control = ALU_AND;
        o_valid       = 1'b1;
        case (i_alu_cls)
            ALU_CLS_ADD: o_alu_control = ALU_ADD;
            ALU_CLS_SUB: o_alu_control = ALU_SUB;
            ALU_CLS_OR:  o_alu_control = ALU_OR;
            ALU_CLS_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_control = ALU_ADD;
                    FN_SUB:  o_alu_control = ALU_SUB;
                    FN_AND:  o_alu_control = ALU_AND;
                    FN_OR:   o_alu_control = ALU_OR;
                    FN_NOR:  o_alu_control = ALU_NOR;
                    FN_SLT:  o_alu_control = ALU_SLT;
                    default: o_valid       = 1'b0;
                endcase
            end
            default: o_alu_control = ALU_AND;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : mc_control
//  Purpose  : Multi-cycle control FSM: fetch/decode/execute/memory/writeback
//             sequencing with a req/ack memory handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mc_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_state_next;
    alu_cls_t   w_alu_cls;
    logic [2:0] w_alu_ctrl;
    logic       w_alu_valid;

    // Outputs decode straight from r_state, so the async reset silences them at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Kept separate from the main decode so the funct-valid feedback is not a comb loop
    always_comb begin
        w_alu_cls = ALU_CLS_NONE;
        case (r_state)
            S_FETCH, S_DECODE, S_MEMADR, S_ADDI: w_alu_cls = ALU_CLS_ADD;
            S_BRANCH:                            w_alu_cls = ALU_CLS_SUB;
            S_ORI:                               w_alu_cls = ALU_CLS_OR;
            S_RTYPE:                             w_alu_cls = ALU_CLS_FUNCT;
            default:                             w_alu_cls = ALU_CLS_NONE;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_cls     (w_alu_cls),
        .i_funct       (funct),
        .o_alu_control (w_alu_ctrl),
        .o_valid       (w_alu_valid)
    );

    assign alu_control = w_alu_ctrl;

    always_comb begin
        w_state_next = r_state;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        pc_src       = 2'b00;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ack) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW, OP_SW:   w_state_next = S_MEMADR;
                    OP_RTYPE:       w_state_next = S_RTYPE;
                    OP_BEQ, OP_BNE: w_state_next = S_BRANCH;
                    OP_ADDI:        w_state_next = S_ADDI;
                    OP_ORI:         w_state_next = S_ORI;
                    OP_J:           w_state_next = S_JUMP;
                    default:        w_state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack) w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ack) w_state_next = S_FETCH;
            end
            S_RTYPE: begin
                alu_src_a    = 1'b1;
                w_state_next = w_alu_valid ? S_RWB : S_ILLEGAL;
            end
            S_RWB: begin
                reg_write    = 1'b1;
                reg_dst      = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                pc_src       = 2'b01;
                pc_write     = (opcode == OP_BNE) ? ~zero : zero;
                w_state_next = S_FETCH;
            end
            S_ADDI: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                w_state_next = S_IWB;
            end
            S_ORI: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b11;
                w_state_next = S_IWB;
            end
            S_IWB: begin
                reg_write    = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_ILLEGAL: illegal = 1'b1;
            default:   w_state_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_control
//  Purpose  : Randomized scoreboard bench for mc_control; an instruction-level
//             model expands each instruction into per-cycle expected controls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

    localparam logic [2:0] C_AND = 3'b000, C_OR = 3'b001, C_NOR = 3'b101;
    localparam logic [2:0] C_ADD = 3'b010, C_SUB = 3'b110, C_SLT = 3'b111;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_BNE = 4,
                   K_ADDI = 5, K_ORI = 6, K_J = 7, K_ILLOP = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ack = 1'b0;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_write, ir_write, iord, mem_req, mem_we;
    logic       reg_write, reg_dst, mem_to_reg, illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [16:0] vec;
        logic        ack;
        logic        z;
        logic        rst;
        logic        abort;
        logic [5:0]  op;
        logic [5:0]  fn;
        string       tag;
    } cyc_t;

    cyc_t cyc_q[$];
    cyc_t exp_q[$];

    mc_control dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_write(pc_write),
        .ir_write(ir_write), .iord(iord), .mem_req(mem_req), .mem_we(mem_we),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] mk(input logic [2:0] alu, input logic a, input logic [1:0] b,
            input logic [1:0] pcs, input logic pcw, input logic irw, input logic io,
            input logic req, input logic we, input logic rw, input logic rd,
            input logic m2r, input logic ill);
        return {alu, a, b, pcs, pcw, irw, io, req, we, rw, rd, m2r, ill};
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Instruction-set meaning of each supported R-type funct
    function automatic bit fn_alu(input logic [5:0] fn, output logic [2:0] alu);
        alu = C_AND;
        case (fn)
            6'b100000: alu = C_ADD;
            6'b100010: alu = C_SUB;
            6'b100100: alu = C_AND;
            6'b100101: alu = C_OR;
            6'b100111: alu = C_NOR;
            6'b101010: alu = C_SLT;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    task automatic push(input logic [16:0] vec, input logic ack, input logic z, input logic rst,
                        input logic abort, input logic [5:0] op, input logic [5:0] fn,
                        input string tag);
        cyc_t c;
        c.vec = vec; c.ack = ack; c.z = z; c.rst = rst; c.abort = abort;
        c.op = op; c.fn = fn; c.tag = tag;
        cyc_q.push_back(c);
    endtask

    task automatic reset_seq(input int n);
        for (int i = 0; i < n; i++)
            push('0, rb(), rb(), 1'b1, 1'b0, 6'($urandom), 6'($urandom), "reset");
        push('0, rb(), rb(), 1'b0, 1'b0, 6'($urandom), 6'($urandom), "idle");
    endtask

    task automatic illegal_tail();
        for (int i = 0; i < 20; i++)
            push(mk(C_AND,0,2'b00,2'b00,0,0,0,0,0,0,0,0,1), rb(), rb(), 0, 0,
                 6'($urandom), 6'($urandom), "illegal_hold");
        reset_seq(2);
    endtask

    // zf: 0/1 forces the ALU zero flag in the branch cycle, anything else randomizes it
    task automatic instr(input int kind, input logic [5:0] fn, input int df, input int dm,
                         input int zf, input bit abort);
        logic [5:0] op;
        logic [2:0] ralu;
        logic       z;
        bit         ok;
        logic [5:0] ill_ops [4] = '{6'b000001, 6'b000011, 6'b001111, 6'b111111};
        case (kind)
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_R:     op = 6'b000000;
            K_BEQ:   op = 6'b000100;
            K_BNE:   op = 6'b000101;
            K_ADDI:  op = 6'b001000;
            K_ORI:   op = 6'b001101;
            K_J:     op = 6'b000010;
            default: op = ill_ops[$urandom_range(0, 3)];
        endcase
        for (int i = 0; i < df; i++)
            push(mk(C_ADD,0,2'b01,2'b00,0,0,0,1,0,0,0,0,0), 1'b0, rb(), 0, 0,
                 6'($urandom), 6'($urandom), "fetch_wait");
        push(mk(C_ADD,0,2'b01,2'b00,1,1,0,1,0,0,0,0,0), 1'b1, rb(), 0, 0, op, fn, "fetch_ack");
        push(mk(C_ADD,0,2'b10,2'b00,0,0,0,0,0,0,0,0,0), rb(), rb(), 0, 0, op, fn, "decode");
        case (kind)
            K_LW, K_SW: begin
                push(mk(C_ADD,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0), rb(), rb(), 0, 0, op, fn, "memadr");
                if (kind == K_LW) begin
                    for (int i = 0; i < dm; i++)
                        push(mk(C_AND,0,2'b00,2'b00,0,0,1,1,0,0,0,0,0), 0, rb(), 0, 0, op, fn, "memrd_wait");
                    push(mk(C_AND,0,2'b00,2'b00,0,0,1,1,0,0,0,0,0), 1, rb(), 0, 0, op, fn, "memrd_ack");
                    push(mk(C_AND,0,2'b00,2'b00,0,0,0,0,0,1,0,1,0), rb(), rb(), 0, 0, op, fn, "memwb");
                end else if (abort) begin
                    push(mk(C_AND,0,2'b00,2'b00,0,0,1,1,1,0,0,0,0), 0, rb(), 0, 1, op, fn, "memwr_abort");
                    reset_seq(3);
                end else begin
                    for (int i = 0; i < dm; i++)
                        push(mk(C_AND,0,2'b00,2'b00,0,0,1,1,1,0,0,0,0), 0, rb(), 0, 0, op, fn, "memwr_wait");
                    push(mk(C_AND,0,2'b00,2'b00,0,0,1,1,1,0,0,0,0), 1, rb(), 0, 0, op, fn, "memwr_ack");
                end
            end
            K_R: begin
                ok = fn_alu(fn, ralu);
                push(mk(ralu,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0), rb(), rb(), 0, 0, op, fn, "rtype");
                if (ok)
                    push(mk(C_AND,0,2'b00,2'b00,0,0,0,0,0,1,1,0,0), rb(), rb(), 0, 0, op, fn, "rwb");
                else
                    illegal_tail();
            end
            K_BEQ, K_BNE: begin
                z = (zf == 0 || zf == 1) ? logic'(zf) : rb();
                push(mk(C_SUB,1,2'b00,2'b01,(kind == K_BEQ) ? z : !z,0,0,0,0,0,0,0,0),
                     rb(), z, 0, 0, op, fn, "branch");
            end
            K_ADDI, K_ORI: begin
                if (kind == K_ADDI)
                    push(mk(C_ADD,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0), rb(), rb(), 0, 0, op, fn, "addi");
                else
                    push(mk(C_OR,1,2'b11,2'b00,0,0,0,0,0,0,0,0,0), rb(), rb(), 0, 0, op, fn, "ori");
                push(mk(C_AND,0,2'b00,2'b00,0,0,0,0,0,1,0,0,0), rb(), rb(), 0, 0, op, fn, "iwb");
            end
            K_J:
                push(mk(C_AND,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0), rb(), rb(), 0, 0, op, fn, "jump");
            default:
                illegal_tail();
        endcase
    endtask

    // Scoreboard monitor: one expected control vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        cyc_t e;
        logic [16:0] act;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {alu_control, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
                   mem_req, mem_we, reg_write, reg_dst, mem_to_reg, illegal};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s @%0t: got %b expected %b (alu|a|b|pcs|pcw irw iord req we rw rd m2r ill)",
                         e.tag, $time, act, e.vec);
            end
        end
    end

    initial begin
        logic [5:0] valid_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
        int k;
        logic [5:0] fn;

        reset_seq(3);
        instr(K_R,   6'b100000, 0, 0, 2, 0);
        instr(K_LW,  6'($urandom), 2, 2, 2, 0);
        instr(K_BEQ, 6'($urandom), 0, 0, 1, 0);
        instr(K_BNE, 6'($urandom), 1, 0, 1, 0);
        instr(K_SW,  6'($urandom), 1, 3, 2, 0);
        instr(K_J,   6'($urandom), 0, 0, 2, 0);
        instr(K_ORI, 6'($urandom), 0, 0, 2, 0);
        instr(K_SW,  6'($urandom), 0, 0, 2, 1);
        instr(K_R,   6'b001000, 0, 0, 2, 0);
        instr(K_ILLOP, 6'($urandom), 0, 0, 2, 0);
        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 29);
            fn = valid_fn[$urandom_range(0, 5)];
            if (k == 29)      instr(K_ILLOP, fn, $urandom_range(0, 2), 0, 2, 0);
            else if (k == 28) instr(K_R, 6'b000000 | 6'($urandom_range(0, 31)), $urandom_range(0, 2), 0, 2, 0);
            else if (k == 27) instr(K_SW, fn, $urandom_range(0, 2), $urandom_range(0, 2), 2, 1);
            else              instr(k % 8, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2, 0);
        end

        while (cyc_q.size() != 0) begin
            cyc_t c;
            c = cyc_q.pop_front();
            @(posedge clk);
            #1;
            rstn    = !c.rst;
            mem_ack = c.ack;
            zero    = c.z;
            opcode  = c.op;
            funct   = c.fn;
            exp_q.push_back(c);
            if (c.abort) begin
                @(negedge clk);
                #2;
                rstn = 1'b0;
                #1;
                checks++;
                if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL async_abort: got mem_req=%b mem_we=%b expected 0 0", mem_req, mem_we);
                end
            end
        end
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
